stream_demux_1_4: RTL
=====================

# stream_demux_1_4

Registered 1-to-4 stream demultiplexer: the distribution-side counterpart of the `mux_4_1` selector. One upstream valid/ready stream carries a W-bit word plus a 2-bit destination select. Each accepted word is steered into a one-entry output slot belonging to one of four downstream valid/ready consumers. The block sits between a shared producer and four independent consumers, and each output stalls independently of the others.

## Interface
Parameters:
- `W`, 4: data width in bits; legal range ≥ 1.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `up_valid`  in  1  upstream word present.
- `up_ready`  out  1  block accepts upstream word this cycle.
- `up_sel`  in  2  destination index 0..3; sampled only when `up_valid`.
- `up_data`  in  W  upstream word.
- `dn_valid`  out  4  bit i: slot i holds a word for consumer i.
- `dn_ready`  in  4  bit i: consumer i accepts slot i this cycle.
- `dn_data0`..`dn_data3`  out  W each  slot contents for consumers 0..3.
- `dn_cnt`  out  4×8 (32)  per-output delivered-word counters, counter i in bits [8i+7:8i]; present only under the configuration macro, see Configuration.

## Operation
- Each output i has one slot: `full_i` and `data_i`. `dn_valid[i]` = `full_i` and `dn_dataI` = `data_i`, both driven directly from registers.
- The upstream side has no internal queue.
- `up_ready` = `~full[up_sel] | dn_ready[up_sel]`. This is combinational from `up_sel`, `dn_ready` and slot state.
- `up_ready` does not depend on `up_valid`.
- An upstream fire is `up_valid & up_ready`. A downstream fire i is `dn_valid[i] & dn_ready[i]`.
- Slot update per clock edge, for each i:
  - load_i = upstream fire with `up_sel == i`.
  - If load_i: `full_i` ← 1 and `data_i` ← `up_data`. This applies whether or not slot i drains in the same cycle.
  - Else if downstream fire i: `full_i` ← 0 and `data_i` is held.
  - Else: hold.
- Words sent to the same destination are delivered in order. Words sent to different destinations have no mutual ordering.
- A stalled output blocks upstream only while `up_sel` points at it. Words for other outputs continue to flow.
- `up_sel` and `up_data` are don't-care when `up_valid` = 0. The block must not change state from them in that case.
- Once a slot's `dn_valid` is asserted, its data must stay stable until the consumer accepts it.

## Timing
- Reset values, applied on the first edge with `rst` = 1 and held while it stays high:
  - `full_*` = 0, so `dn_valid` = 4'b0000.
  - `data_*` = 0, so `dn_data0..3` = 0.
  - `dn_cnt` = 0.
- While `rst` = 1, `up_ready` is forced to 0.
- Latency: a word accepted at edge N is visible on `dn_valid[i]`/`dn_dataI` immediately after edge N, i.e. 1 cycle.
- Throughput:
  - One word per cycle to any output whose consumer holds `dn_ready` high, because a drain and a load in the same cycle are allowed.
  - Back-to-back words to different outputs: one per cycle.
- Full slot with `dn_ready[i]` = 0: `up_ready` = 0 while `up_sel` = i, and the word waits upstream.
- Reset asserted mid-transfer: held slot contents are discarded with no delivery. A downstream fire in that same cycle is ignored, and counters do not increment.
- Counter wrap: 8'hFF + 1 → 8'h00, with no saturation.

## Configuration
- Macro: `STREAM_DEMUX_1_4_CNT_EN`.
- Defined:
  - `dn_cnt[8i+7:8i]` increments by 1 on every downstream fire i.
  - Reset value is 0; the counter wraps modulo 256.
- Undefined:
  - No counter registers are built and `dn_cnt` is tied to 32'h0.
  - The port list is unchanged, so benches are identical in both builds.
- Data path and handshake behaviour are identical with or without the macro.

## Test plan
- Reset then idle:
  - Stimulus: `rst` = 1 for 2 cycles, then `up_valid` = 0.
  - Required: `dn_valid` = 0000, all `dn_data` = 0, `up_ready` = 0 during reset, and `up_ready` = 1 after reset.
- Single route:
  - Stimulus: `up_data` = 4'hA, `up_sel` = 2, `dn_ready` = 0000.
  - Required: the next cycle shows `dn_valid` = 0100 and `dn_data2` = A.
  - Then raise `dn_ready[2]`: `dn_valid` = 0000 one cycle later.
- Backpressure isolation:
  - Stimulus: slot 1 full with `dn_ready[1]` = 0, then present `up_sel` = 1 with data 5.
  - Required: `up_ready` = 0 and slot 1 keeps its old data.
  - Then switch to `up_sel` = 3 with data 7: `up_ready` = 1 and `dn_data3` = 7 next cycle.
- Full-rate streaming:
  - Stimulus: `dn_ready` = 1111, 8 consecutive words 1..8 with `up_sel` = 0.
  - Required: `up_ready` stays 1 and `dn_data0` shows 1..8 on consecutive cycles, one cycle delayed.
  - With the macro defined, `dn_cnt[7:0]` = 8 afterwards.
- Simultaneous drain and load:
  - Stimulus: slot 0 holds 3, `dn_ready[0]` = 1, and upstream presents 9 to sel 0 in the same cycle.
  - Required: the consumer takes 3 and next cycle `dn_valid[0]` = 1 with `dn_data0` = 9.
- Reset mid-operation and counter wrap:
  - Stimulus: 255 deliveries to output 3, then one more.
  - Required: `dn_cnt[31:24]` = 0.
  - Then fill all four slots and assert `rst` for 1 cycle: `dn_valid` = 0000 and `dn_cnt` = 0.

Source files
------------

// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 valid/ready demultiplexer with one output slot per consumer; optional per-output delivery counters under STREAM_DEMUX_1_4_CNT_EN.
// Latency: 1 cycle from upstream accept to dn_valid/dn_dataN; a slot may drain and reload in the same cycle.
// Backpressure: up_ready drops only while up_sel points at a full slot whose consumer is stalled; other outputs keep flowing.
module stream_demux_1_4 #(
    parameter int W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            up_valid,
    output logic            up_ready,
    input  logic [1:0]      up_sel,
    input  logic [W-1:0]    up_data,
    output logic [3:0]      dn_valid,
    input  logic [3:0]      dn_ready,
    output logic [W-1:0]    dn_data0,
    output logic [W-1:0]    dn_data1,
    output logic [W-1:0]    dn_data2,
    output logic [W-1:0]    dn_data3,
    output logic [31:0]     dn_cnt
);

    logic [3:0]   full;
    logic [W-1:0] data [4];
    logic         up_fire;
    logic [3:0]   load;
    logic [3:0]   dn_fire;

    // Readiness ignores up_valid so the producer may look before committing.
    always_comb begin
        up_ready = 1'b0;
        if (!rst) begin
            up_ready = ~full[up_sel] | dn_ready[up_sel];
        end
    end

    assign up_fire = up_valid & up_ready;
    assign dn_fire = full & dn_ready;

    always_comb begin
        load = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            load[i] = up_fire & (up_sel == 2'(i));
        end
    end

    // A load wins over a drain: the slot is refilled in the cycle it empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    full[i] <= 1'b1;
                    data[i] <= up_data;
                end else if (dn_fire[i]) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    assign dn_valid = full;
    assign dn_data0 = data[0];
    assign dn_data1 = data[1];
    assign dn_data2 = data[2];
    assign dn_data3 = data[3];

`ifdef STREAM_DEMUX_1_4_CNT_EN
    logic [7:0] cnt [4];

    // Free-running delivery counters; wrap modulo 256 by design.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (dn_fire[i]) begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    assign dn_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`else
    assign dn_cnt = 32'h0;
`endif

endmodule
